// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snake_pkg
// Brief   : Command codes, direction encodings, game-state enum and the
//           reversal helper shared by the snake step controller.
// Rev     : 1.0  initial release
// ============================================================================
package snake_pkg;

    localparam logic [7:0] CMD_UP    = 8'd1;
    localparam logic [7:0] CMD_LEFT  = 8'd2;
    localparam logic [7:0] CMD_DOWN  = 8'd3;
    localparam logic [7:0] CMD_RIGHT = 8'd4;
    localparam logic [7:0] CMD_START = 8'd5;
    localparam logic [7:0] CMD_PAUSE = 8'd6;
    localparam logic [7:0] CMD_MODE0 = 8'd7;
    localparam logic [7:0] CMD_MODE1 = 8'd8;
    localparam logic [7:0] CMD_MODE2 = 8'd9;
    localparam logic [7:0] CMD_MODE3 = 8'd10;
    localparam logic [7:0] CMD_AGAIN = 8'd11;

    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
        return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
               ((a == DIR_DOWN)  && (b == DIR_UP))    ||
               ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
               ((a == DIR_RIGHT) && (b == DIR_LEFT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_fifo.sv
`default_nettype none
// ============================================================================
// Module  : snake_dir_fifo
// Brief   : Small direction queue with flush; a pop frees its slot before a
//           simultaneous push so a full queue still accepts push+pop.
// Rev     : 1.0  initial release
// ============================================================================
module snake_dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     push,
    input  logic [2:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic [2:0]               head
);

    localparam int             c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

    logic [2:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_do_pop  = pop && (r_level != '0);
    assign w_do_push = push && ((r_level != c_full) || w_do_pop);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: reads are qualified by a non-zero level.
    always_ff @(posedge sys_clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign level = r_level;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/snake_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : snake_step_ctrl
// Brief   : Game FSM, mode-scaled step tick and per-step direction apply.
//           SNAKE_DIR_QUEUE_EN selects a DIR_FIFO_DEPTH queue, otherwise a
//           single last-write-wins holding register.
// Rev     : 1.0  initial release
// ============================================================================
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_CYC       = 12_500_000,
    parameter int DIR_FIFO_DEPTH = 4
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              cmd_valid,
    input  logic [7:0]                        cmd_data,
    input  logic                              collision,
    output logic                              step,
    output logic [2:0]                        direction,
    output logic [1:0]                        game_state,
    output logic                              game_rst,
    output logic [1:0]                        mode,
    output logic [$clog2(DIR_FIFO_DEPTH):0]   q_level
);

    localparam int          c_cnt_w = $clog2(TICK_CYC);
    localparam int          c_lvl_w = $clog2(DIR_FIFO_DEPTH) + 1;
    localparam logic [31:0] c_tick  = 32'(TICK_CYC);

    game_state_t        r_state;
    game_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [1:0]         r_mode;
    logic [1:0]         w_mode_val;
    logic [2:0]         r_dir;
    logic               r_step;
    logic               r_game_rst;

    logic               w_cmd_start;
    logic               w_cmd_pause;
    logic               w_cmd_again;
    logic               w_cmd_dir;
    logic               w_cmd_mode;
    logic [31:0]        w_period_m1;
    logic               w_at_wrap;
    logic               w_tick_hit;
    logic               w_push;
    logic               w_pop;
    logic               w_apply;
    logic [2:0]         w_head;
    logic [c_lvl_w-1:0] w_level;
    logic               w_q_nonempty;

    assign w_cmd_start = cmd_valid && (cmd_data == CMD_START);
    assign w_cmd_pause = cmd_valid && (cmd_data == CMD_PAUSE);
    assign w_cmd_again = cmd_valid && (cmd_data == CMD_AGAIN);
    assign w_cmd_dir   = cmd_valid && (cmd_data >= CMD_UP) && (cmd_data <= CMD_RIGHT);
    assign w_cmd_mode  = cmd_valid && (cmd_data >= CMD_MODE0) && (cmd_data <= CMD_MODE3);

    always_comb begin
        w_mode_val = 2'd0;
        case (cmd_data)
            CMD_MODE1: w_mode_val = 2'd1;
            CMD_MODE2: w_mode_val = 2'd2;
            CMD_MODE3: w_mode_val = 2'd3;
            default:   w_mode_val = 2'd0;
        endcase
    end

    assign w_period_m1 = (c_tick >> r_mode) - 32'd1;
    assign w_at_wrap   = ({{(32 - c_cnt_w){1'b0}}, r_cnt} == w_period_m1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd_again) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_cmd_start) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (collision)        w_state_nxt = ST_OVER;
                    else if (w_cmd_pause) w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (w_cmd_start) w_state_nxt = ST_RUN;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Priority AGAIN > collision > PAUSE > step; a mode change restarts the period.
    always_comb begin
        w_tick_hit = 1'b0;
        w_cnt_nxt  = r_cnt;
        if (w_cmd_again || w_cmd_mode) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (collision) begin
                        w_cnt_nxt = '0;
                    end else if (!w_cmd_pause) begin
                        if (w_at_wrap) begin
                            w_tick_hit = 1'b1;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                ST_PAUSE: w_cnt_nxt = r_cnt;
                default:  w_cnt_nxt = '0;
            endcase
        end
    end

    assign w_push       = (r_state == ST_RUN) && w_cmd_dir;
    assign w_q_nonempty = (w_level != '0);
    assign w_pop        = w_tick_hit && w_q_nonempty;
    assign w_apply      = w_pop && (w_head != r_dir) && !is_reverse(w_head, r_dir);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt      <= '0;
            r_step     <= 1'b0;
            r_game_rst <= 1'b0;
            r_mode     <= 2'd0;
            r_dir      <= DIR_RIGHT;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_step     <= w_tick_hit;
            r_game_rst <= w_cmd_again;
            if (w_cmd_mode) begin
                r_mode <= w_mode_val;
            end
            if (w_cmd_again) begin
                r_dir <= DIR_RIGHT;
            end else if (w_apply) begin
                r_dir <= w_head;
            end
        end
    end

`ifdef SNAKE_DIR_QUEUE_EN
    snake_dir_fifo #(
        .DEPTH     (DIR_FIFO_DEPTH)
    ) u_dir_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (w_push),
        .push_data (cmd_data[2:0]),
        .pop       (w_pop),
        .flush     (w_cmd_again),
        .level     (w_level),
        .head      (w_head)
    );
`else
    logic       r_hold_vld;
    logic [2:0] r_hold_dir;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hold_vld <= 1'b0;
            r_hold_dir <= DIR_RIGHT;
        end else if (w_cmd_again) begin
            r_hold_vld <= 1'b0;
        end else if (w_push) begin
            r_hold_vld <= 1'b1;
            r_hold_dir <= cmd_data[2:0];
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign w_head  = r_hold_dir;
    assign w_level = {{(c_lvl_w - 1){1'b0}}, r_hold_vld};
`endif

    assign step       = r_step;
    assign direction  = r_dir;
    assign game_state = r_state;
    assign game_rst   = r_game_rst;
    assign mode       = r_mode;
    assign q_level    = w_level;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_snake_step_ctrl
// Brief   : Directed bench with a cycle model and literal timing/queue checks.
// Rev     : 1.0  initial release
// ============================================================================
module tb_snake_step_ctrl;

    localparam int TICK  = 16;
    localparam int DEPTH = 4;
`ifdef SNAKE_DIR_QUEUE_EN
    localparam int QUEUED = 1;
    localparam int CAP    = DEPTH;
`else
    localparam int QUEUED = 0;
    localparam int CAP    = 1;
`endif
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVER = 3;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       collision;
    logic       step;
    logic [2:0] direction;
    logic [1:0] game_state;
    logic       game_rst;
    logic [1:0] mode;
    logic [2:0] q_level;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    snake_step_ctrl #(.TICK_CYC(TICK), .DIR_FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .collision(collision), .step(step),
        .direction(direction), .game_state(game_state), .game_rst(game_rst),
        .mode(mode), .q_level(q_level)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_dir, m_mode, m_cnt, m_step, m_grst;
    int m_q[$];

    function automatic bit opposite(input int a, input int b);
        return (a == 1 && b == 3) || (a == 3 && b == 1) || (a == 2 && b == 4) || (a == 4 && b == 2);
    endfunction

    task automatic model_cycle();
        int  c;
        int  per;
        bit  was_run;
        bit  fire;
        int  head;
        c       = cmd_valid ? int'(cmd_data) : 0;
        per     = TICK >> m_mode;
        was_run = (m_state == S_RUN);
        fire    = 0;
        m_grst  = 0;
        if (c == 11) begin
            m_state = S_IDLE; m_grst = 1; m_q.delete(); m_dir = 4; m_cnt = 0;
        end else begin
            if (c >= 7 && c <= 10) begin
                m_mode = c - 7;
                m_cnt  = 0;
            end else if (was_run && !collision && c != 6) begin
                if (m_cnt == per - 1) begin fire = 1; m_cnt = 0; end
                else m_cnt++;
            end
            if (was_run && collision) begin
                m_state = S_OVER; m_cnt = 0;
            end else if (was_run && c == 6) begin
                m_state = S_PAUSE;
            end else if ((m_state == S_IDLE || m_state == S_PAUSE) && c == 5) begin
                m_state = S_RUN;
            end
            if (fire && m_q.size() > 0) begin
                head = m_q.pop_front();
                if (head != m_dir && !opposite(head, m_dir)) m_dir = head;
            end
            if (was_run && c >= 1 && c <= 4) begin
                if (m_q.size() < CAP) m_q.push_back(c);
                else if (QUEUED == 0) begin m_q.delete(); m_q.push_back(c); end
            end
        end
        m_step = fire;
    endtask

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_state = S_IDLE; m_dir = 4; m_mode = 0; m_cnt = 0;
            m_step = 0; m_grst = 0; m_q.delete();
        end else begin
            model_cycle();
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("m_step",      step,       m_step);
            chk("m_direction", direction,  m_dir);
            chk("m_state",     game_state, m_state);
            chk("m_game_rst",  game_rst,   m_grst);
            chk("m_mode",      mode,       m_mode);
            chk("m_q_level",   q_level,    m_q.size());
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input int c);
        cmd_valid = 1'b1;
        cmd_data  = 8'(c);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'd0;
    endtask

    task automatic wait_step(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge sys_clk);
            if (step) begin n = i; break; end
        end
    endtask

    task automatic count_steps(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            if (step) cnt++;
        end
    endtask

    int n;
    int exp_dir[4];
    int exp_lvl[4];

    initial begin
        if (QUEUED != 0) begin
            exp_dir = '{1, 2, 3, 4}; exp_lvl = '{3, 2, 1, 0};
        end else begin
            exp_dir = '{1, 1, 1, 1}; exp_lvl = '{0, 0, 0, 0};
        end
        sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'd0; collision = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_en = 1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_state", game_state, 0);
        chk("rst_dir", direction, 4);
        chk("rst_mode", mode, 0);
        chk("rst_qlevel", q_level, 0);
        count_steps(100, n);
        chk("idle_no_step", n, 0);

        // START: first step TICK cycles after RUN entry, then every TICK
        send(5);
        chk("start_run", game_state, 1);
        wait_step(n); chk("first_step_gap", n, 16);
        wait_step(n); chk("second_step_gap", n, 16);

        // mode sweep
        send(10);
        chk("mode3", mode, 3);
        wait_step(n); chk("mode3_gap_a", n, 2);
        wait_step(n); chk("mode3_gap_b", n, 2);
        send(8);
        chk("mode1", mode, 1);
        wait_step(n); chk("mode1_gap_a", n, 8);
        wait_step(n); chk("mode1_gap_b", n, 8);
        send(7);

        // queue fill with overflow
        send(1); send(2); send(3); send(4); send(1);
        chk("queue_fill", q_level, CAP);
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            chk("queue_step_seen", n > 0, 1);
            chk("queue_dir", direction, exp_dir[i]);
            chk("queue_level", q_level, exp_lvl[i]);
        end

        // reversal rejected at apply time
        send(4);
        wait_step(n);
        chk("dir_right", direction, 4);
        send(2);
        chk("rev_level_pre", q_level, 1);
        wait_step(n);
        chk("rev_dir_kept", direction, 4);
        chk("rev_level_post", q_level, 0);

        // pause at counter 9, resume after 7 cycles
        repeat (9) @(negedge sys_clk);
        send(6);
        chk("paused", game_state, 2);
        send(1); send(2);
        chk("pause_dir_discard", q_level, 0);
        count_steps(48, n);
        chk("pause_no_step", n, 0);
        send(5);
        chk("resumed", game_state, 1);
        wait_step(n); chk("resume_gap", n, 7);

        // collision together with AGAIN
        collision = 1'b1;
        send(11);
        collision = 1'b0;
        chk("again_idle", game_state, 0);
        chk("again_rst_pulse", game_rst, 1);
        chk("again_dir", direction, 4);
        @(negedge sys_clk);
        chk("again_rst_single", game_rst, 0);

        // collision coinciding with the wrap cycle
        send(5);
        repeat (15) @(negedge sys_clk);
        collision = 1'b1;
        @(negedge sys_clk);
        chk("over_state", game_state, 3);
        chk("over_no_step", step, 0);
        count_steps(30, n);
        chk("over_quiet", n, 0);
        send(5);
        chk("over_start_ignored", game_state, 3);
        collision = 1'b0;

        // reset mid-count with a pending direction
        send(11); send(5); send(1); send(2);
        repeat (13) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_state", game_state, 0);
        chk("arst_qlevel", q_level, 0);
        chk("arst_step", step, 0);
        chk("arst_dir", direction, 4);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        count_steps(40, n);
        chk("arst_no_step", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_step_ctrl.md
# snake_step_ctrl

Game sequencer between the UART command decoder and the snake datapath. Consumes decoded command bytes, runs the game-state FSM, generates the snake step tick at a mode-dependent rate, and queues direction commands so they are applied one per step. Reversal commands are rejected at the moment they are applied.

## Interface
- `TICK_CYC`, default 12_500_000: base step period in `sys_clk` cycles for mode 0. Minimum value is 16.
- `DIR_FIFO_DEPTH`, default 4: depth of the direction queue. Must be a power of 2, at least 2.
- `sys_clk`, in, 1: 50 MHz system clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: one-cycle strobe; `cmd_data` is valid in that cycle.
- `cmd_data`, in, 8: command byte. Codes:
  - 1/2/3/4: UP/LEFT/DOWN/RIGHT
  - 5: START
  - 6: PAUSE
  - 7–10: MODE0–MODE3
  - 11: AGAIN
- `collision`, in, 1: level from the game datapath; sampled only in RUN.
- `step`, out, 1: one-cycle pulse; the datapath advances the snake once per pulse.
- `direction`, out, 3: 1=UP, 2=LEFT, 3=DOWN, 4=RIGHT.
- `game_state`, out, 2: 0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.
- `game_rst`, out, 1: one-cycle pulse that clears the playfield.
- `mode`, out, 2: current speed mode.
- `q_level`, out, $clog2(DIR_FIFO_DEPTH)+1: number of queued direction commands.

## Operation
Reset values:
- `game_state`=IDLE, `direction`=4 (RIGHT), `mode`=0.
- `step`=0, `game_rst`=0, `q_level`=0.
- Tick counter = 0.

FSM transitions. Only codes listed above have effect; other codes are ignored.
- IDLE --START--> RUN
- RUN --PAUSE--> PAUSE
- PAUSE --START--> RUN
- RUN --collision--> OVER
- any --AGAIN--> IDLE, with these effects:
  - pulse `game_rst`
  - flush the queue
  - set `direction`=RIGHT
  - clear the tick counter
- START in OVER or RUN: ignored.
- PAUSE in IDLE, PAUSE or OVER: ignored.

Mode commands (7–10):
- Accepted in every state; set `mode` = code−7.
- Clear the tick counter.

Direction commands (1–4):
- In RUN: pushed to the queue. If the queue is full, the new command is dropped.
- In any other state: discarded.

Step generation:
- Tick period P = TICK_CYC >> mode (mode 3 gives TICK_CYC/8).
- In RUN the counter increments each cycle. When it reaches P−1 it wraps to 0 and `step` fires.
- In PAUSE the counter holds its value; it resumes from that value on START.
- In IDLE and OVER the counter is 0.

Applying a queued direction on each step:
- If the queue is non-empty, pop the head.
- If the head is a reversal of the current `direction` (UP↔DOWN, LEFT↔RIGHT) or equals it, discard it. `direction` is unchanged and the next entry is not popped this step.
- Otherwise set `direction` to the head.

Simultaneous events:
- AGAIN has priority over collision, collision over PAUSE, and PAUSE over a step.
- When collision and the step condition occur in the same cycle, the state goes to OVER and no `step` is issued.
- A push and a pop in the same cycle are both performed, even when the queue is full (the pop frees a slot first).

## Timing
- `step`, the new `direction` value and the `q_level` decrement are registered together. They become visible in the cycle after the counter equals P−1.
- Command latency: `cmd_valid` at edge N is reflected in `game_state`, `mode`, `q_level` and `game_rst` after edge N+1.
- From entering RUN with the counter at 0, the first `step` appears P cycles later; consecutive steps are spaced P cycles.
- `game_rst` is high for exactly one cycle per AGAIN.
- Asserting reset mid-step or mid-queue forces all reset values immediately; no pulse is emitted after release.

## Configuration
- `SNAKE_DIR_QUEUE_EN` defined: direction queue of `DIR_FIFO_DEPTH` entries as described above.
- Not defined: a single-entry holding register, last-write-wins. A new direction command overwrites the pending one instead of being dropped. `q_level` is 0 or 1. Reversal filtering at step time is unchanged.

## Structure
- Package `snake_pkg` holds:
  - command code constants (`CMD_UP` … `CMD_AGAIN`)
  - direction encodings
  - the `game_state` enum
  - a `is_reverse(a,b)` function
- Sub-module `snake_dir_fifo` (push, pop, flush, level, head) is instantiated under `SNAKE_DIR_QUEUE_EN`. The FSM, tick counter and apply logic stay in the top module.

## Test plan
All scenarios use `TICK_CYC`=16 and `DIR_FIFO_DEPTH`=4.
- Reset release → IDLE, `direction`=4, `mode`=0, no `step` for 100 cycles; START → first `step` 16 cycles after RUN entry, then every 16 cycles.
- Mode sweep: MODE3 in RUN → counter cleared, steps every 2 cycles; MODE1 → every 8 cycles.
- Queue: in RUN send UP, LEFT, DOWN, RIGHT, UP → `q_level`=4 and the 5th is dropped. Successive steps give `direction`=1, 2, 3, 4.
- Reversal: `direction`=4, send LEFT → next `step` keeps 4 and `q_level` goes 1→0.
- PAUSE at counter=9, wait 50 cycles, START → next `step` 7 cycles after START takes effect; direction commands sent while paused leave `q_level` at 0.
- `collision` and AGAIN in the same cycle → IDLE with `game_rst` pulsed; then `collision` alone in RUN → OVER, no `step`, and START is ignored.
